// File: rtl/game_pkg.sv
// Shared definitions for the game session controller: state encoding,
// score limits and the BCD increment helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        WIN     = 3'd2,
        RESPAWN = 3'd3,
        OVER    = 3'd4
    } game_state_t;

    localparam logic [15:0] SCORE_MAX  = 16'h9999;
    localparam int          BCD_DIGITS = 4;

    // Add one to a packed BCD value, rippling the carry digit by digit.
    function automatic logic [15:0] bcdIncrement(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        logic [3:0]  digit;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            digit = value[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[4*i +: 4] = digit + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[4*i +: 4] = digit;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/game_session_bcd_counter.sv
// Four-digit BCD counter with synchronous clear and saturation at SCORE_MAX.
module bcd_counter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] value
);

    // Count register: clear wins over increment, increment stops at the maximum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= 16'h0000;
        end else if (clear) begin
            value <= 16'h0000;
        end else if (inc && (value != SCORE_MAX)) begin
            value <= bcdIncrement(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/game_session.sv
// Game life-cycle controller: sequences idle, play, banners and game over,
// drives the core reset and keeps score, high score, lives and wave.
module game_session
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int BANNER_CYCLES = 200_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        killPulse,
    input  logic        victory,
    input  logic        defeat,
    output logic        coreReset,
    output logic [2:0]  state,
    output logic [15:0] score,
    output logic [15:0] hiScore,
    output logic [2:0]  lives,
    output logic [3:0]  wave
);

    localparam int TIMER_W = $clog2(BANNER_CYCLES + 1);

    game_state_t        stateR;
    game_state_t        stateNext;
    logic               armedR;
    logic [TIMER_W-1:0] timerR;
    logic               scoreClear;
    logic               scoreInc;
    logic               loseLife;
    logic               clearWave;

    bcd_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clear (scoreClear),
        .inc   (scoreInc),
        .value (score)
    );

    // Next-state decode; defeat outranks victory, and both wait for arming.
    always_comb begin
        stateNext  = stateR;
        scoreClear = 1'b0;
        scoreInc   = 1'b0;
        loseLife   = 1'b0;
        clearWave  = 1'b0;
        case (stateR)
            IDLE: begin
                if (start) begin
                    stateNext  = PLAY;
                    scoreClear = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            PLAY: begin
                scoreInc = killPulse;
                if (armedR && defeat) begin
                    loseLife  = 1'b1;
                    stateNext = (lives == 3'd1) ? OVER : RESPAWN;
                end else if (armedR && victory) begin
                    clearWave = 1'b1;
                    stateNext = WIN;
                end else begin
                    stateNext = PLAY;
                end
            end
            WIN, RESPAWN: begin
                if (timerR == '0) begin
                    stateNext = PLAY;
                end else begin
                    stateNext = stateR;
                end
            end
            OVER: begin
                if (start) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = OVER;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, arming, core reset and banner timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateR    <= IDLE;
            armedR    <= 1'b0;
            coreReset <= 1'b0;
            timerR    <= '0;
        end else begin
            stateR    <= stateNext;
            armedR    <= (stateR == PLAY);
            coreReset <= (stateR == PLAY);
            if (loseLife || clearWave) begin
                timerR <= TIMER_W'(BANNER_CYCLES - 1);
            end else if (timerR != '0) begin
                timerR <= timerR - TIMER_W'(1);
            end else begin
                timerR <= timerR;
            end
        end
    end

    // Lives, wave and high score; BCD compares correctly as plain unsigned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lives   <= 3'd0;
            wave    <= 4'd0;
            hiScore <= 16'h0000;
        end else begin
            if (scoreClear) begin
                lives <= 3'(LIVES);
                wave  <= 4'd1;
            end else begin
                lives <= loseLife ? (lives - 3'd1) : lives;
                wave  <= (clearWave && (wave != 4'd15)) ? (wave + 4'd1) : wave;
            end
            if ((stateR == OVER) && (score > hiScore)) begin
                hiScore <= score;
            end else begin
                hiScore <= hiScore;
            end
        end
    end

    assign state = stateR;

endmodule

// File: tb/tb_game_session.sv
// Self-checking bench for game_session: directed scenarios plus randomized
// traffic compared against a decimal, event-level model of the game rules.
module tb_game_session;

    localparam int LIVES  = 3;
    localparam int BANNER = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        killPulse = 1'b0;
    logic        victory = 1'b0;
    logic        defeat = 1'b0;
    logic        coreReset;
    logic [2:0]  state;
    logic [15:0] score;
    logic [15:0] hiScore;
    logic [2:0]  lives;
    logic [3:0]  wave;

    int checks = 0;
    int failures = 0;

    // Model: states 0 idle, 1 play, 2 win, 3 respawn, 4 over; scores in decimal.
    int mState, mScore, mHi, mLives, mWave, mAge, mBanner;
    bit mCore;

    game_session #(.LIVES(LIVES), .BANNER_CYCLES(BANNER)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .killPulse (killPulse),
        .victory   (victory),
        .defeat    (defeat),
        .coreReset (coreReset),
        .state     (state),
        .score     (score),
        .hiScore   (hiScore),
        .lives     (lives),
        .wave      (wave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic modelReset();
        mState = 0; mScore = 0; mHi = 0; mLives = 0; mWave = 0;
        mAge = 0; mBanner = 0; mCore = 1'b0;
    endtask

    task automatic modelStep();
        mCore = (mState == 1);
        case (mState)
            0: if (start) begin
                mScore = 0; mLives = LIVES; mWave = 1; mAge = 0; mState = 1;
            end
            1: begin
                if (killPulse && mScore < 9999) mScore++;
                if (mAge >= 1 && defeat) begin
                    mLives--;
                    mState = (mLives == 0) ? 4 : 3;
                    mBanner = BANNER;
                end else if (mAge >= 1 && victory) begin
                    if (mWave < 15) mWave++;
                    mState = 2;
                    mBanner = BANNER;
                end else begin
                    mAge++;
                end
            end
            2, 3: begin
                mBanner--;
                if (mBanner == 0) begin mState = 1; mAge = 0; end
            end
            4: begin
                if (mScore > mHi) mHi = mScore;
                if (start) mState = 0;
            end
            default: mState = 0;
        endcase
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        start = 1'b0; killPulse = 1'b0; victory = 1'b0; defeat = 1'b0;
        reset = 1'b0;
        modelReset();
        #2;
        reset = 1'b1;
    endtask

    task automatic waitPlay();
        for (int i = 0; i < 20 && state != 3'd1; i++) tick();
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL banner_timeout: state=%0d required=1", state);
        end
    endtask

    task automatic loseLife();
        defeat = 1'b1;
        tick();
        defeat = 1'b0;
        if (state == 3'd3) begin
            waitPlay();
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        doReset();
        checks++;
        if (state !== 3'd0 || coreReset !== 1'b0 || score !== 16'h0000 ||
            hiScore !== 16'h0000 || lives !== 3'd0 || wave !== 4'd0) begin
            failures++;
            $display("FAIL reset_values: state=%0d core=%0b score=%h hi=%h lives=%0d wave=%0d required all zero",
                     state, coreReset, score, hiScore, lives, wave);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (state !== 3'd1 || coreReset !== 1'b0) begin
            failures++;
            $display("FAIL start_to_play: state=%0d core=%0b required state=1 core=0", state, coreReset);
        end
        tick();
        checks++;
        if (coreReset !== 1'b1 || lives !== 3'd3 || wave !== 4'd1) begin
            failures++;
            $display("FAIL core_release: core=%0b lives=%0d wave=%0d required core=1 lives=3 wave=1",
                     coreReset, lives, wave);
        end
    endtask

    task automatic test_scoring();
        killPulse = 1'b1;
        repeat (12) tick();
        checks++;
        if (score !== 16'h0012) begin
            failures++; $display("FAIL score_12: score=%h required=0012", score);
        end
        repeat (87) tick();
        checks++;
        if (score !== 16'h0099) begin
            failures++; $display("FAIL score_99: score=%h required=0099", score);
        end
        tick();
        checks++;
        if (score !== 16'h0100) begin
            failures++; $display("FAIL score_carry: score=%h required=0100", score);
        end
        repeat (9899) tick();
        checks++;
        if (score !== 16'h9999) begin
            failures++; $display("FAIL score_9999: score=%h required=9999", score);
        end
        repeat (5) tick();
        killPulse = 1'b0;
        checks++;
        if (score !== 16'h9999 || state !== 3'd1) begin
            failures++; $display("FAIL score_saturate: score=%h state=%0d required 9999 in state 1", score, state);
        end
    endtask

    task automatic test_wave_cleared();
        logic [15:0] saved;
        int n;
        saved = score;
        victory = 1'b1;
        tick();
        victory = 1'b0;
        checks++;
        if (state !== 3'd2) begin
            failures++; $display("FAIL win_entry: state=%0d required=2", state);
        end
        n = 1;
        for (int g = 0; g < 20; g++) begin
            tick();
            if (state != 3'd2) break;
            n++;
            checks++;
            if (coreReset !== 1'b0) begin
                failures++; $display("FAIL win_core_reset: core=%0b required=0", coreReset);
            end
        end
        checks++;
        if (n !== BANNER || state !== 3'd1 || wave !== 4'd2 || score !== saved) begin
            failures++;
            $display("FAIL win_exit: cycles=%0d state=%0d wave=%0d score=%h required 4 1 2 %h",
                     n, state, wave, score, saved);
        end
        victory = 1'b1;
        tick();
        victory = 1'b0;
        checks++;
        if (state !== 3'd1 || wave !== 4'd2) begin
            failures++; $display("FAIL unarmed_victory: state=%0d wave=%0d required state=1 wave=2", state, wave);
        end
    endtask

    task automatic test_lives();
        defeat = 1'b1;
        tick();
        defeat = 1'b0;
        checks++;
        if (state !== 3'd3 || lives !== 3'd2) begin
            failures++; $display("FAIL first_death: state=%0d lives=%0d required 3 2", state, lives);
        end
        waitPlay();
        tick();
        defeat = 1'b1;
        tick();
        defeat = 1'b0;
        checks++;
        if (state !== 3'd3 || lives !== 3'd1) begin
            failures++; $display("FAIL second_death: state=%0d lives=%0d required 3 1", state, lives);
        end
        waitPlay();
        tick();
        victory = 1'b1;
        defeat = 1'b1;
        tick();
        victory = 1'b0;
        defeat = 1'b0;
        checks++;
        if (state !== 3'd4 || lives !== 3'd0 || wave !== 4'd2) begin
            failures++; $display("FAIL defeat_priority: state=%0d lives=%0d wave=%0d required 4 0 2", state, lives, wave);
        end
        tick();
        checks++;
        if (hiScore !== 16'h9999) begin
            failures++; $display("FAIL hiscore_saturated: hi=%h required=9999", hiScore);
        end
    endtask

    task automatic test_hiscore();
        doReset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        killPulse = 1'b1;
        repeat (42) tick();
        killPulse = 1'b0;
        repeat (3) loseLife();
        tick();
        checks++;
        if (state !== 3'd4 || hiScore !== 16'h0042) begin
            failures++; $display("FAIL hiscore_first: state=%0d hi=%h required 4 0042", state, hiScore);
        end
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        killPulse = 1'b1;
        repeat (30) tick();
        killPulse = 1'b0;
        repeat (3) loseLife();
        tick();
        checks++;
        if (state !== 3'd4 || hiScore !== 16'h0042 || score !== 16'h0030) begin
            failures++;
            $display("FAIL hiscore_kept: state=%0d hi=%h score=%h required 4 0042 0030", state, hiScore, score);
        end
    endtask

    task automatic test_async_abort();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        killPulse = 1'b1;
        tick();
        killPulse = 1'b0;
        defeat = 1'b1;
        tick();
        defeat = 1'b0;
        tick();
        checks++;
        if (state !== 3'd3) begin
            failures++; $display("FAIL abort_setup: state=%0d required=3", state);
        end
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if (state !== 3'd0 || coreReset !== 1'b0 || score !== 16'h0000 ||
            hiScore !== 16'h0000 || lives !== 3'd0 || wave !== 4'd0) begin
            failures++;
            $display("FAIL async_abort: state=%0d core=%0b score=%h hi=%h lives=%0d wave=%0d required all zero",
                     state, coreReset, score, hiScore, lives, wave);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (state !== 3'd0) begin
            failures++; $display("FAIL abort_stays_idle: state=%0d required=0", state);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            killPulse = ($urandom_range(0, 2) == 0);
            victory   = ($urandom_range(0, 24) == 0);
            defeat    = ($urandom_range(0, 29) == 0);
            tick();
            checks++;
            if (state !== 3'(mState) || coreReset !== mCore || score !== toBcd(mScore) ||
                hiScore !== toBcd(mHi) || lives !== 3'(mLives) || wave !== 4'(mWave)) begin
                failures++;
                $display("FAIL random_cycle_%0d: state=%0d core=%0b score=%h hi=%h lives=%0d wave=%0d required %0d %0b %h %h %0d %0d",
                         i, state, coreReset, score, hiScore, lives, wave,
                         mState, mCore, toBcd(mScore), toBcd(mHi), mLives, mWave);
            end
        end
        start = 1'b0; killPulse = 1'b0; victory = 1'b0; defeat = 1'b0;
    endtask

    initial begin
        modelReset();
        test_reset();
        test_scoring();
        test_wave_cleared();
        test_lives();
        test_hiscore();
        test_async_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
